am_modulator: RTL

// Digital AM signal generator, transmit-side counterpart of the ma measurement path.
// Two DDS phase accumulators produce a carrier and a modulating tone.

---
 rtl/am_pkg.sv | 18 +
 rtl/am_sine_lut.sv | 27 ++
 rtl/am_modulator.sv | 116 +++++++++++
 3 files changed

// File: rtl/am_pkg.sv
// am_pkg: shared constants and helpers for the AM modulator slice.
package am_pkg;
  localparam int DAC_MID   = 512;
  localparam int MA_MIN    = 30;
  localparam int MA_MAX    = 100;
  localparam int MA_FRAC_K = 10486;
  localparam int ENV_ONE   = 1024;
  localparam int LUT_AMP   = 511;

  function automatic logic [7:0] clamp_ma(input logic [7:0] m);
    return (m < 8'(MA_MIN)) ? 8'(MA_MIN) : (m > 8'(MA_MAX)) ? 8'(MA_MAX) : m;
  endfunction

  // Percent to Q1.10: 100 maps to exactly 1024.
  function automatic logic [10:0] ma_to_frac(input logic [7:0] m);
    return 11'((32'(m) * 32'(MA_FRAC_K)) >> 10);
  endfunction
endpackage

// File: rtl/am_sine_lut.sv
// am_sine_lut: full-cycle signed 10-bit sine ROM with a registered read port.
module am_sine_lut
  import am_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic [ADDR_W-1:0]       addr_i,
  output logic signed [9:0]       data_o
);
  localparam real PI = 3.14159265358979;

  function automatic logic signed [9:0] sine_at(input int a);
    real v;
    v = real'(LUT_AMP) * $sin(2.0 * PI * real'(a) / (2.0 ** ADDR_W));
    return 10'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
  endfunction

  logic signed [9:0] rom [2**ADDR_W];

  for (genvar a = 0; a < 2**ADDR_W; a++) begin : g_rom
    assign rom[a] = sine_at(a);
  end

  always_ff @(posedge clk)
    data_o <= rom[addr_i];
endmodule

// File: rtl/am_modulator.sv
// am_modulator: dual-DDS AM generator producing offset-binary samples for a 10-bit test DAC.
// Depth changes are deferred to a modulating-period boundary so the envelope never jumps mid-cycle.
module am_modulator
  import am_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] fc_word,
  input  logic [PHASE_W-1:0] fm_word,
  input  logic [7:0]         ma_in,
  input  logic               ma_load,
  output logic [9:0]         dac_data,
  output logic               dac_valid,
  output logic [7:0]         ma_active,
  output logic               ma_pending
);
  logic [PHASE_W-1:0] phase_c_q, phase_m_q;
  logic [PHASE_W:0]   sum_m;
  logic               fm_wrap;
  logic signed [9:0]  sc, sm, sc_q;
  logic [7:0]         ma_active_q, ma_active_d, ma_pend_q, ma_pend_d, ma_clamped;
  logic               ma_pending_q, ma_pending_d;
  logic [10:0]        ma_frac_q;
  logic               v1_q, v2_q, v3_q, dac_valid_q;
  logic [11:0]        env_q, env_d;
  logic signed [10:0] p_q, p_d;
  logic [9:0]         dac_q, dac_d;
  logic signed [21:0] prod_m;
  logic signed [22:0] prod_c;

  assign sum_m   = {1'b0, phase_m_q} + {1'b0, fm_word};
  assign fm_wrap = enable & sum_m[PHASE_W];

  am_sine_lut #(.ADDR_W(ADDR_W)) u_lut_c (
    .clk    (clk),
    .addr_i (phase_c_q[PHASE_W-1 -: ADDR_W]),
    .data_o (sc)
  );

  am_sine_lut #(.ADDR_W(ADDR_W)) u_lut_m (
    .clk    (clk),
    .addr_i (phase_m_q[PHASE_W-1 -: ADDR_W]),
    .data_o (sm)
  );

  // A load coinciding with a wrap, or while stopped, bypasses the pending slot.
  always_comb begin
    ma_clamped   = clamp_ma(ma_in);
    ma_active_d  = ma_active_q;
    ma_pend_d    = ma_pend_q;
    ma_pending_d = ma_pending_q;
    if (ma_load && (!enable || fm_wrap)) begin
      ma_active_d  = ma_clamped;
      ma_pending_d = 1'b0;
    end else if (ma_load) begin
      ma_pend_d    = ma_clamped;
      ma_pending_d = 1'b1;
    end else if (fm_wrap && ma_pending_q) begin
      ma_active_d  = ma_pend_q;
      ma_pending_d = 1'b0;
    end
  end

  always_comb begin
    prod_m = $signed({1'b0, ma_frac_q}) * sm;
    env_d  = 12'(ENV_ONE + (prod_m >>> 9));
    prod_c = $signed({1'b0, env_q}) * sc_q;
    p_d    = 11'(prod_c >>> 11);
    dac_d  = v3_q ? 10'(DAC_MID + p_q) : 10'(DAC_MID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_c_q    <= '0;
      phase_m_q    <= '0;
      ma_active_q  <= 8'(MA_MIN);
      ma_pend_q    <= 8'(MA_MIN);
      ma_pending_q <= 1'b0;
      ma_frac_q    <= ma_to_frac(8'(MA_MIN));
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      dac_valid_q  <= 1'b0;
      sc_q         <= '0;
      env_q        <= 12'(ENV_ONE);
      p_q          <= '0;
      dac_q        <= 10'(DAC_MID);
    end else begin
      if (enable) begin
        phase_c_q <= phase_c_q + fc_word;
        phase_m_q <= sum_m[PHASE_W-1:0];
      end
      ma_active_q  <= ma_active_d;
      ma_pend_q    <= ma_pend_d;
      ma_pending_q <= ma_pending_d;
      ma_frac_q    <= ma_to_frac(ma_active_d);
      v1_q         <= enable;
      v2_q         <= v1_q;
      v3_q         <= v2_q;
      dac_valid_q  <= v3_q;
      sc_q         <= sc;
      env_q        <= env_d;
      p_q          <= p_d;
      dac_q        <= dac_d;
    end
  end

  assign dac_data   = dac_q;
  assign dac_valid  = dac_valid_q;
  assign ma_active  = ma_active_q;
  assign ma_pending = ma_pending_q;
endmodule
